// File: rtl/hyperram_pkg.sv
// Shared types and helpers for the HyperRAM transaction sequencer:
// state encoding, command/address layout and initial-latency arithmetic.
package hyperram_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CA,
        S_LAT,
        S_WR,
        S_RD,
        S_DRAIN,
        S_CSHI
    } state_t;

    localparam int CA_RW_BIT    = 47;
    localparam int CA_AS_BIT    = 46;
    localparam int CA_BURST_BIT = 45;
    localparam int CA_ROW_HI    = 44;
    localparam int CA_ROW_LO    = 16;
    localparam int CA_COL_HI    = 2;

    function automatic logic [47:0] build_ca(input logic write, input logic [31:0] addr);
        logic [47:0] ca;
        ca = '0;
        ca[CA_RW_BIT]              = ~write;
        ca[CA_AS_BIT]              = 1'b0;
        ca[CA_BURST_BIT]           = 1'b1;
        ca[CA_ROW_HI:CA_ROW_LO]    = addr[31:3];
        ca[CA_COL_HI:0]            = addr[2:0];
        return ca;
    endfunction

    // Three CK cycles of latency are already covered by the CA beats.
    function automatic int lat_wait(input int latency_clks, input int fixed_2x);
        int v;
        v = latency_clks * (1 + ((fixed_2x != 0) ? 1 : 0)) - 3;
        return (v < 1) ? 1 : v;
    endfunction

endpackage

// File: rtl/hyperram_rd_align.sv
// Delays the read-beat CK enable to the cycle its word is valid on the pad
// data bus, then registers that word onto the read stream.
module hyperram_rd_align #(
    parameter int RD_DELAY = 3
) (
    input  logic        clk0,
    input  logic        rst_n,
    input  logic        beat,
    input  logic [15:0] dataout,
    output logic [15:0] rdata,
    output logic        rdata_valid
);

    logic [RD_DELAY-1:0] vld_pipe;

    always_ff @(posedge clk0) begin
        if (!rst_n) begin
            vld_pipe    <= '0;
            rdata       <= '0;
            rdata_valid <= 1'b0;
        end else begin
            vld_pipe[0] <= beat;
            for (int i = 1; i < RD_DELAY; i++) vld_pipe[i] <= vld_pipe[i-1];
            rdata_valid <= vld_pipe[RD_DELAY-1];
            if (vld_pipe[RD_DELAY-1]) rdata <= dataout;
        end
    end

endmodule

// File: rtl/hyperram_seq.sv
// HyperRAM burst sequencer: CA beats, initial latency, write streaming with
// CK pause on data starvation, read beats plus drain, and CS# high time.
module hyperram_seq
    import hyperram_pkg::*;
#(
    parameter int LATENCY_CLKS = 6,
    parameter int FIXED_2X     = 1,
    parameter int MAX_BURST    = 64,
    parameter int RD_DELAY     = 3,
    parameter int CSHI_CLKS    = 2
) (
    input  logic        clk0,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [7:0]  req_len,
    input  logic [15:0] wdata,
    input  logic        wdata_valid,
    output logic        wdata_ready,
    output logic [15:0] rdata,
    output logic        rdata_valid,
    output logic        busy,
    output logic [15:0] datain,
    input  logic [15:0] dataout,
    output logic        oe_clk,
    output logic        oe_data,
    output logic        cs_n
);

    localparam int LW      = lat_wait(LATENCY_CLKS, FIXED_2X);
    localparam int LCW_RAW = $clog2(2 * LATENCY_CLKS);
    localparam int LCW     = (LCW_RAW < 1) ? 1 : LCW_RAW;

    localparam logic [LCW-1:0] LAT_LAST   = LCW'(LW - 1);
    localparam logic [7:0]     MAXB       = 8'(MAX_BURST);
    localparam logic [7:0]     DRAIN_LAST = 8'(RD_DELAY - 1);
    localparam logic [7:0]     CSHI_LAST  = 8'(CSHI_CLKS - 1);

    state_t         state, state_n;
    logic [7:0]     cnt, cnt_n;
    logic [LCW-1:0] lat_cnt, lat_n;
    logic [7:0]     len_q, len_eff;
    logic           wr_q;
    logic [31:0]    ca_sh;
    logic [47:0]    ca_new;
    logic           acc, wr_take, rd_beat;
    logic [15:0]    datain_n;
    logic           oe_clk_n, oe_data_n;

    assign ca_new  = build_ca(req_write, req_addr);
    assign len_eff = (req_len == 8'd0) ? 8'd1 : ((req_len > MAXB) ? MAXB : req_len);

    assign req_ready   = rst_n && (state == S_IDLE);
    // The first word is taken in the last latency cycle so it hits DQ on the first data beat.
    assign wdata_ready = rst_n && ((state == S_LAT && lat_cnt == LAT_LAST && wr_q) ||
                                   (state == S_WR && cnt != len_q));
    assign acc     = req_valid && req_ready;
    assign wr_take = wdata_valid && wdata_ready;

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        lat_n     = lat_cnt;
        datain_n  = '0;
        oe_clk_n  = 1'b0;
        oe_data_n = 1'b0;
        case (state)
            S_IDLE: if (acc) begin
                state_n = S_CA;
                cnt_n   = '0;
            end
            S_CA: if (cnt == 8'd2) begin
                state_n = S_LAT;
                cnt_n   = '0;
                lat_n   = '0;
            end else cnt_n = cnt + 8'd1;
            S_LAT: if (lat_cnt == LAT_LAST) begin
                state_n = wr_q ? S_WR : S_RD;
                cnt_n   = wr_take ? 8'd1 : 8'd0;
                lat_n   = '0;
            end else lat_n = lat_cnt + LCW'(1);
            S_WR: if (cnt == len_q) begin
                state_n = S_CSHI;
                cnt_n   = '0;
            end else if (wr_take) cnt_n = cnt + 8'd1;
            S_RD: if (cnt == len_q - 8'd1) begin
                state_n = S_DRAIN;
                cnt_n   = '0;
            end else cnt_n = cnt + 8'd1;
            S_DRAIN: if (cnt == DRAIN_LAST) begin
                state_n = S_CSHI;
                cnt_n   = '0;
            end else cnt_n = cnt + 8'd1;
            S_CSHI: if (cnt == CSHI_LAST) begin
                state_n = S_IDLE;
                cnt_n   = '0;
            end else cnt_n = cnt + 8'd1;
            default: state_n = S_IDLE;
        endcase
        // Registered pad controls describe the cycle being entered.
        case (state_n)
            S_CA: begin
                oe_clk_n  = 1'b1;
                oe_data_n = 1'b1;
                datain_n  = (state == S_IDLE) ? ca_new[47:32] : ca_sh[31:16];
            end
            S_LAT, S_RD: oe_clk_n = 1'b1;
            S_WR: begin
                oe_clk_n  = wr_take;
                oe_data_n = wr_take;
                datain_n  = wr_take ? wdata : 16'h0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk0) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            cnt     <= '0;
            lat_cnt <= '0;
            len_q   <= '0;
            wr_q    <= 1'b0;
            ca_sh   <= '0;
            datain  <= '0;
            oe_clk  <= 1'b0;
            oe_data <= 1'b0;
            cs_n    <= 1'b1;
            busy    <= 1'b0;
            rd_beat <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            lat_cnt <= lat_n;
            if (acc) begin
                len_q <= len_eff;
                wr_q  <= req_write;
                ca_sh <= ca_new[31:0];
            end else if (state == S_CA) begin
                ca_sh <= {ca_sh[15:0], 16'h0};
            end
            datain  <= datain_n;
            oe_clk  <= oe_clk_n;
            oe_data <= oe_data_n;
            cs_n    <= (state_n == S_IDLE) || (state_n == S_CSHI);
            busy    <= (state_n != S_IDLE);
            rd_beat <= (state_n == S_RD);
        end
    end

    hyperram_rd_align #(.RD_DELAY(RD_DELAY)) u_rd_align (
        .clk0        (clk0),
        .rst_n       (rst_n),
        .beat        (rd_beat),
        .dataout     (dataout),
        .rdata       (rdata),
        .rdata_valid (rdata_valid)
    );

endmodule
